// File: rtl/seg_input_conditioner_pkg.sv
// Shared types and defaults for the seg input conditioner.
// FSM state encodings and default timing constants shared with the seg top.
package seg_input_conditioner_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } seg_state_t;

  localparam int unsigned DEF_DATA_W          = 16;
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_ACK_TIMEOUT     = 255;

  // Counter width that holds 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_input_conditioner_debounce.sv
// seg_debounce: synchroniser, debounce counter, stable level, rise pulse.
// Ports: clk, rst_n, din (raw async) -> level (debounced), rise (1-cycle).
module seg_debounce
  import seg_input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   level_q;
  logic                   level_d1_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  // The level only flips after the input has disagreed with it for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      level_q    <= 1'b0;
      level_d1_q <= 1'b0;
    end else begin
      level_d1_q <= level_q;
      if (synced == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= ~level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~level_d1_q;

endmodule

// File: rtl/seg_input_conditioner.sv
// Turns BTNC/SW into one Wishbone-style write per debounced press.
// Ports: CLK100MHZ, CPU_RESETN, BTNC, SW, ACK_I -> DAT_O, STB_O, WE_O, BUSY_O, ERR_O.
module seg_input_conditioner
  import seg_input_conditioner_pkg::*;
#(
  parameter int unsigned DATA_W          = DEF_DATA_W,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned ACK_TIMEOUT     = DEF_ACK_TIMEOUT
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic              BTNC,
  input  logic [DATA_W-1:0] SW,
  input  logic              ACK_I,
  output logic [DATA_W-1:0] DAT_O,
  output logic              STB_O,
  output logic              WE_O,
  output logic              BUSY_O,
  output logic              ERR_O
);

  localparam int unsigned TW = cnt_w(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 1);

  logic                               btn_level;
  logic                               btn_rise;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] sw_sync_q;
  logic [DATA_W-1:0]                  sw_synced;
  seg_state_t                         state_q;
  logic [TW-1:0]                      timer_q;

  seg_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clk   (CLK100MHZ),
    .rst_n (CPU_RESETN),
    .din   (BTNC),
    .level (btn_level),
    .rise  (btn_rise)
  );

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sw_sync_q <= '0;
    end else begin
      sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], SW};
    end
  end

  assign sw_synced = sw_sync_q[SYNC_STAGES-1];

  // S_HOLD waits for release so a long hold never yields a second write.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      DAT_O   <= '0;
      STB_O   <= 1'b0;
      WE_O    <= 1'b0;
      BUSY_O  <= 1'b0;
      ERR_O   <= 1'b0;
    end else begin
      ERR_O <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (btn_rise) begin
            DAT_O   <= sw_synced;
            STB_O   <= 1'b1;
            WE_O    <= 1'b1;
            BUSY_O  <= 1'b1;
            timer_q <= '0;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (ACK_I) begin
            STB_O   <= 1'b0;
            WE_O    <= 1'b0;
            state_q <= S_HOLD;
          end else if (timer_q == TMR_LAST) begin
            STB_O   <= 1'b0;
            WE_O    <= 1'b0;
            ERR_O   <= 1'b1;
            state_q <= S_HOLD;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_HOLD: begin
          if (!btn_level) begin
            BUSY_O  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          STB_O   <= 1'b0;
          WE_O    <= 1'b0;
          BUSY_O  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_input_conditioner.sv
// Scoreboard bench for seg_input_conditioner.
// Stimulus pushes expected writes; a negedge monitor pops and checks them.
module tb_seg_input_conditioner;

  localparam int DEB = 4;
  localparam int TMO = 8;
  localparam int SYN = 2;
  localparam int LAT = SYN + DEB + 1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        btnc  = 1'b0;
  logic        ack   = 1'b0;
  logic [15:0] sw    = '0;
  logic [15:0] dat;
  logic        stb;
  logic        we;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  seg_input_conditioner #(
    .DATA_W          (16),
    .SYNC_STAGES     (SYN),
    .DEBOUNCE_CYCLES (DEB),
    .ACK_TIMEOUT     (TMO)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .BTNC       (btnc),
    .SW         (sw),
    .ACK_I      (ack),
    .DAT_O      (dat),
    .STB_O      (stb),
    .WE_O       (we),
    .BUSY_O     (busy),
    .ERR_O      (err)
  );

  typedef struct {
    logic [15:0] data;
    int          width;
    bit          err;
    int          rise_cyc;
  } exp_t;

  exp_t sb[$];
  int   total      = 0;
  int   bad        = 0;
  int   cyc        = 0;
  int   err_cycles = 0;
  int   rises      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input int w, input bit e,
                      input int rc);
    exp_t x;
    x.data     = d;
    x.width    = w;
    x.err      = e;
    x.rise_cyc = rc;
    sb.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_stb(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (stb) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Monitor
  bit          in_flight = 1'b0;
  logic        stb_prev  = 1'b0;
  exp_t        cur;
  int          width     = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_flight = 1'b0;
      stb_prev  = 1'b0;
    end else begin
      if (err) err_cycles++;
      chk("we_eq_stb", we, stb);
      if (stb && !stb_prev) begin
        rises++;
        if (sb.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          cur       = sb.pop_front();
          in_flight = 1'b1;
          width     = 1;
          chk("dat", dat, cur.data);
          chk("latency", cyc, cur.rise_cyc);
        end
      end else if (stb && in_flight) begin
        width++;
        chk("dat_frozen", dat, cur.data);
      end else if (!stb && stb_prev && in_flight) begin
        in_flight = 1'b0;
        chk("stb_width", width, cur.width);
        chk("err_at_drop", err, cur.err);
      end
      stb_prev = stb;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int e0;
    int r0;
    bit ok;
    bit busy_seen;

    // reset state
    tick(3);
    chk("rst_dat", dat, 0);
    chk("rst_stb", stb, 0);
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick(2);

    // single press, ACK tied high
    sw  = 16'h1234;
    ack = 1'b1;
    e0  = err_cycles;
    c0  = cyc;
    btnc = 1'b1;
    push(16'h1234, 1, 1'b0, c0 + LAT);
    tick(20);
    btnc = 1'b0;
    tick(12);
    chk("t1_err_none", err_cycles - e0, 0);
    chk("t1_idle", busy, 0);

    // bounce shorter than the debounce window
    r0 = rises;
    busy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btnc = 1'b1;
      for (int j = 0; j < 2; j++) begin
        tick(1);
        busy_seen |= busy;
      end
      btnc = 1'b0;
      for (int j = 0; j < 2; j++) begin
        tick(1);
        busy_seen |= busy;
      end
    end
    tick(10);
    chk("t2_no_write", rises - r0, 0);
    chk("t2_busy_never", busy_seen, 0);

    // late ACK, SW changes during the wait
    ack  = 1'b0;
    sw   = 16'h1234;
    c0   = cyc;
    btnc = 1'b1;
    push(16'h1234, 4, 1'b0, c0 + LAT);
    wait_stb(ok);
    chk("t3_stb_seen", ok, 1);
    tick(1);
    sw = 16'hBEEF;
    tick(2);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(4);
    btnc = 1'b0;
    tick(12);
    chk("t3_dat_held", dat, 16'h1234);

    // ACK never arrives
    ack  = 1'b0;
    sw   = 16'h5A5A;
    e0   = err_cycles;
    c0   = cyc;
    btnc = 1'b1;
    push(16'h5A5A, TMO, 1'b1, c0 + LAT);
    wait_stb(ok);
    chk("t4_stb_seen", ok, 1);
    tick(12);
    chk("t4_err_pulse", err_cycles - e0, 1);
    chk("t4_stb_low", stb, 0);
    chk("t4_hold_busy", busy, 1);
    tick(10);
    chk("t4_hold_still", busy, 1);
    btnc = 1'b0;
    tick(12);
    chk("t4_released", busy, 0);

    // reset mid-request, button held through release
    ack  = 1'b0;
    sw   = 16'h1234;
    e0   = err_cycles;
    c0   = cyc;
    btnc = 1'b1;
    push(16'h1234, 0, 1'b0, c0 + LAT);
    wait_stb(ok);
    chk("t5_stb_seen", ok, 1);
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_stb", stb, 0);
    chk("t5_async_we", we, 0);
    chk("t5_async_dat", dat, 0);
    chk("t5_async_busy", busy, 0);
    tick(1);
    ack   = 1'b1;
    rst_n = 1'b1;
    c0    = cyc;
    push(16'h1234, 1, 1'b0, c0 + LAT);
    tick(15);
    btnc = 1'b0;
    tick(12);
    chk("t5_no_err", err_cycles - e0, 0);

    // press, release, press
    ack  = 1'b1;
    sw   = 16'h0001;
    c0   = cyc;
    btnc = 1'b1;
    push(16'h0001, 1, 1'b0, c0 + LAT);
    tick(12);
    btnc = 1'b0;
    tick(12);
    sw   = 16'h0002;
    c0   = cyc;
    btnc = 1'b1;
    push(16'h0002, 1, 1'b0, c0 + LAT);
    tick(12);
    btnc = 1'b0;
    tick(12);

    chk("sb_empty", sb.size(), 0);
    chk("no_inflight", in_flight, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
